mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_if.sv | 37 +++
 rtl/mbist_march_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mbist_march_if.sv
// Control, status and normal-mode RAM bus of the March C- BIST controller.
// The slave side is the controller; the master side is whoever requests tests and uses the RAM.
interface mbist_march_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          start;
    logic          bg_all;
    logic          stop_on_fail;
    logic          cs;
    logic          rwbar;
    logic [AW-1:0] addr;
    logic [DW-1:0] ramin;
    logic [DW-1:0] ramout;
    logic          inj_en;
    logic [AW-1:0] inj_addr;
    logic [DW-1:0] inj_mask;
    logic [DW-1:0] inj_val;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic          fail_bg;

    modport master (
        output start, bg_all, stop_on_fail, cs, rwbar, addr, ramin,
               inj_en, inj_addr, inj_mask, inj_val,
        input  ramout, busy, done, fail, fail_addr, fail_elem, fail_bg
    );

    modport slave (
        input  start, bg_all, stop_on_fail, cs, rwbar, addr, ramin,
               inj_en, inj_addr, inj_mask, inj_val,
        output ramout, busy, done, fail, fail_addr, fail_elem, fail_bg
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller wrapped around an N x DW RAM with a stuck-bit fault injector.
// One march operation per cycle; reads are checked one cycle after ramout is loaded.
module mbist_march_ctrl #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic         clk,
    input  logic         rst,
    mbist_march_if.slave bus
);
    localparam int N = 1 << AW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_reg;
    logic          busy_reg, done_reg, drain_reg;
    logic          bg_reg, bg_all_reg, stop_reg;
    logic [2:0]    elem_reg;
    logic [AW-1:0] addr_reg;
    logic          phase_reg;
    logic          fail_reg, fail_bg_reg;
    logic [AW-1:0] fail_addr_reg;
    logic [2:0]    fail_elem_reg;
    logic          cmp_valid_reg, cmp_bg_reg;
    logic [DW-1:0] cmp_exp_reg;
    logic [AW-1:0] cmp_addr_reg;
    logic [2:0]    cmp_elem_reg;
    logic [DW-1:0] ramout_reg;
    logic [DW-1:0] mem [N];

    logic [DW-1:0] chk_pat, pat_b, op_data, rd_word, ram_wdata;
    logic [AW-1:0] ram_addr;
    logic          op_read, two_op, addr_end, mismatch, halt, issue, ram_en, ram_we;

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_chk
            assign chk_pat[gi] = ((gi % 2) == 0);
        end
    endgenerate

    // E0 writes only, E5 reads only, E1..E4 read then write each address.
    always_comb begin
        pat_b    = bg_reg ? chk_pat : '0;
        two_op   = (elem_reg >= 3'd1) && (elem_reg <= 3'd4);
        op_read  = (elem_reg != 3'd0) && !phase_reg;
        op_data  = pat_b;
        if (op_read && (elem_reg == 3'd2 || elem_reg == 3'd4))
            op_data = ~pat_b;
        if (!op_read && (elem_reg == 3'd1 || elem_reg == 3'd3))
            op_data = ~pat_b;
        addr_end = (elem_reg < 3'd3) ? (addr_reg == '1) : (addr_reg == '0);
        mismatch = cmp_valid_reg && (ramout_reg != cmp_exp_reg);
        halt     = mismatch && stop_reg;
        issue    = (state_reg == RUN) && !halt;
    end

    always_comb begin
        if (busy_reg) begin
            ram_en    = issue;
            ram_we    = issue && !op_read;
            ram_addr  = addr_reg;
            ram_wdata = op_data;
        end else begin
            ram_en    = bus.cs;
            ram_we    = bus.cs && !bus.rwbar;
            ram_addr  = bus.addr;
            ram_wdata = bus.ramin;
        end
        rd_word = mem[ram_addr];
        if (bus.inj_en && ram_addr == bus.inj_addr)
            rd_word = (rd_word & ~bus.inj_mask) | (bus.inj_val & bus.inj_mask);
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ramout_reg <= '0;
        else if (ram_en && !ram_we)
            ramout_reg <= rd_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            drain_reg     <= 1'b0;
            bg_reg        <= 1'b0;
            bg_all_reg    <= 1'b0;
            stop_reg      <= 1'b0;
            elem_reg      <= '0;
            addr_reg      <= '0;
            phase_reg     <= 1'b0;
            fail_reg      <= 1'b0;
            fail_addr_reg <= '0;
            fail_elem_reg <= '0;
            fail_bg_reg   <= 1'b0;
            cmp_valid_reg <= 1'b0;
            cmp_exp_reg   <= '0;
            cmp_addr_reg  <= '0;
            cmp_elem_reg  <= '0;
            cmp_bg_reg    <= 1'b0;
        end else begin
            cmp_valid_reg <= issue && op_read;
            cmp_exp_reg   <= op_data;
            cmp_addr_reg  <= addr_reg;
            cmp_elem_reg  <= elem_reg;
            cmp_bg_reg    <= bg_reg;
            if (mismatch && !fail_reg) begin
                fail_reg      <= 1'b1;
                fail_addr_reg <= cmp_addr_reg;
                fail_elem_reg <= cmp_elem_reg;
                fail_bg_reg   <= cmp_bg_reg;
            end
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_reg     <= RUN;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        fail_reg      <= 1'b0;
                        fail_addr_reg <= '0;
                        fail_elem_reg <= '0;
                        fail_bg_reg   <= 1'b0;
                        bg_all_reg    <= bus.bg_all;
                        stop_reg      <= bus.stop_on_fail;
                        bg_reg        <= 1'b0;
                        elem_reg      <= '0;
                        addr_reg      <= '0;
                        phase_reg     <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (two_op && !phase_reg) begin
                        phase_reg <= 1'b1;
                    end else begin
                        phase_reg <= 1'b0;
                        if (!addr_end) begin
                            addr_reg <= (elem_reg < 3'd3) ? addr_reg + 1'b1 : addr_reg - 1'b1;
                        end else if (elem_reg != 3'd5) begin
                            // E0->E1 and E1->E2 restart at 0; later elements start at the top.
                            elem_reg <= elem_reg + 3'd1;
                            addr_reg <= (elem_reg < 3'd2) ? '0 : '1;
                        end else if (!bg_reg && bg_all_reg) begin
                            bg_reg   <= 1'b1;
                            elem_reg <= '0;
                            addr_reg <= '0;
                        end else begin
                            state_reg <= DRAIN;
                            drain_reg <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (halt || drain_reg) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ramout    = ramout_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.fail      = fail_reg;
    assign bus.fail_addr = fail_addr_reg;
    assign bus.fail_elem = fail_elem_reg;
    assign bus.fail_bg   = fail_bg_reg;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: directed and randomized March C- runs checked against a
// behavioural model that replays the march algorithm on a plain array.
module tb_mbist_march_ctrl;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mbist_march_if #(.AW(AW), .DW(DW)) bus ();
    mbist_march_ctrl #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_mem [N];
    bit            exp_fail;
    int            exp_faddr, exp_felem, exp_fbg, exp_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Replays March C- on exp_mem; operation k executes at edge k+1, its read is judged at k+2.
    task automatic model_run(input bit bgall, input bit stop, input bit ie, input logic [AW-1:0] ia,
                             input logic [DW-1:0] im, input logic [DW-1:0] iv);
        int opidx = 0;
        logic [DW-1:0] b, got, want;
        exp_fail = 0; exp_faddr = 0; exp_felem = 0; exp_fbg = 0;
        for (int p = 0; p < (bgall ? 2 : 1); p++) begin
            b = (p == 1) ? 8'h55 : 8'h00;
            for (int e = 0; e < 6; e++) begin
                for (int i = 0; i < N; i++) begin
                    int a;
                    a = (e < 3) ? i : N - 1 - i;
                    if (e != 0) begin
                        want = (e == 2 || e == 4) ? ~b : b;
                        got  = exp_mem[a];
                        if (ie && a == int'(ia)) got = (got & ~im) | (iv & im);
                        if (got != want && !exp_fail) begin
                            exp_fail = 1; exp_faddr = a; exp_felem = e; exp_fbg = p;
                            if (stop) begin
                                exp_done = opidx + 2;
                                return;
                            end
                        end
                        opidx++;
                    end
                    if (e != 5) begin
                        exp_mem[a] = (e == 1 || e == 3) ? ~b : b;
                        opidx++;
                    end
                end
            end
        end
        exp_done = opidx + 2;
    endtask

    task automatic readback(input string tag);
        bus.inj_en = 1'b0;
        for (int a = 0; a < N; a++) begin
            bus.cs = 1'b1; bus.rwbar = 1'b1; bus.addr = AW'(a);
            tick();
            check_eq($sformatf("%s mem[%0d]", tag, a), 32'(bus.ramout), 32'(exp_mem[a]));
        end
        bus.cs = 1'b0;
    endtask

    // Normal-mode traffic aimed at 0x2C is driven throughout the run and must be ignored.
    task automatic run_test(input string tag, input bit bgall, input bit stop, input bit ie,
                            input logic [AW-1:0] ia, input logic [DW-1:0] im, input logic [DW-1:0] iv);
        int n = 0;
        bus.bg_all = bgall; bus.stop_on_fail = stop;
        bus.inj_en = ie; bus.inj_addr = ia; bus.inj_mask = im; bus.inj_val = iv;
        model_run(bgall, stop, ie, ia, im, iv);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
        do begin
            bus.cs = 1'b1; bus.rwbar = 1'($urandom_range(0, 1));
            bus.addr = 6'h2C; bus.ramin = 8'hF1;
            tick();
            n++;
        end while (!bus.done && n < 3000);
        bus.cs = 1'b0;
        check_eq({tag, " done_edge"}, 32'(n), 32'(exp_done));
        check_eq({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        check_eq({tag, " fail"}, 32'(bus.fail), 32'(exp_fail));
        if (exp_fail) begin
            check_eq({tag, " fail_addr"}, 32'(bus.fail_addr), 32'(exp_faddr));
            check_eq({tag, " fail_elem"}, 32'(bus.fail_elem), 32'(exp_felem));
            check_eq({tag, " fail_bg"}, 32'(bus.fail_bg), 32'(exp_fbg));
        end
        $display("run %s bg_all=%0d stop=%0d inj=%0d@%0h m=%0h v=%0h done_edge=%0d fail=%0d",
                 tag, bgall, stop, ie, ia, im, iv, n, bus.fail);
        readback(tag);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.bg_all = 1'b0; bus.stop_on_fail = 1'b0;
        bus.cs = 1'b0; bus.rwbar = 1'b1; bus.addr = '0; bus.ramin = '0;
        bus.inj_en = 1'b0; bus.inj_addr = '0; bus.inj_mask = '0; bus.inj_val = '0;
        for (int a = 0; a < N; a++) exp_mem[a] = '0;
        tick(); tick();
        check_eq("rst busy", 32'(bus.busy), 32'd0);
        check_eq("rst done", 32'(bus.done), 32'd0);
        check_eq("rst fail", 32'(bus.fail), 32'd0);
        check_eq("rst fail_addr", 32'(bus.fail_addr), 32'd0);
        check_eq("rst fail_elem", 32'(bus.fail_elem), 32'd0);
        check_eq("rst fail_bg", 32'(bus.fail_bg), 32'd0);
        check_eq("rst ramout", 32'(bus.ramout), 32'd0);
        rst = 1'b0;

        bus.cs = 1'b1; bus.rwbar = 1'b0; bus.addr = 6'h2C; bus.ramin = 8'hF1;
        tick();
        bus.rwbar = 1'b1;
        tick();
        bus.cs = 1'b0;
        check_eq("normal rd 2C", 32'(bus.ramout), 32'hF1);
        $display("normal write/read 0x2C ramout=%0h", bus.ramout);

        run_test("solid", 1'b0, 1'b0, 1'b0, '0, '0, '0);
        run_test("both", 1'b1, 1'b0, 1'b0, '0, '0, '0);
        run_test("inj", 1'b0, 1'b0, 1'b1, 6'h2C, 8'h01, 8'h01);
        run_test("inj_stop", 1'b0, 1'b1, 1'b1, 6'h2C, 8'h01, 8'h01);

        bus.inj_en = 1'b0; bus.bg_all = 1'b1; bus.stop_on_fail = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 300; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst busy", 32'(bus.busy), 32'd0);
        check_eq("midrst done", 32'(bus.done), 32'd0);
        check_eq("midrst fail", 32'(bus.fail), 32'd0);
        $display("reset at edge 300 busy=%0d done=%0d", bus.busy, bus.done);
        run_test("after_rst", 1'b0, 1'b0, 1'b0, '0, '0, '0);

        for (int r = 0; r < 6; r++) begin
            run_test($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'b1, AW'($urandom), DW'($urandom_range(1, 255)), DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
